// File: rtl/pwm_dac_pkg.sv
// Shared synth constants: sample width, prescaler width, run mode.
// Also used by the wave generator so sample ranges stay in step.
package pwm_dac_pkg;

    localparam int WAVE_DEPTH = 8;
    localparam int WAVE_MAX   = (1 << WAVE_DEPTH) - 1;
    localparam int DIV_WIDTH  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_t;

endpackage

// File: rtl/pwm_dac_tick_divider.sv
// Prescaler: one-clock step every divider+1 clocks while enabled.
// Reused for the envelope rate; divider is sampled live.
module tick_divider
    import pwm_dac_pkg::*;
#(
    parameter int DW = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] divider,
    output logic          step
);

    logic [DW-1:0] cnt;

    assign step = enable && (cnt == divider);

    // count 0..divider; a divider lowered under the count wraps at max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_dac.sv
// Voice output stage: double-buffered samples rendered as PWM duty.
// One sample per PWM period; starvation raises a sticky underrun.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WD = WAVE_DEPTH,
    parameter int DW = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WD-1:0] sample,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [DW-1:0] divider,
    input  logic          enable,
    input  logic          underrun_clear,
    output logic          pwm_out,
    output logic          sample_tick,
    output logic          underrun
);

    localparam int            WMAX = (1 << WD) - 1;
    localparam logic [WD-1:0] LAST = WD'(WMAX - 1);

    mode_t         mode;
    logic          run;
    logic          step;
    logic          boundary;
    logic          accept;
    logic          hold_valid;
    logic [WD-1:0] hold;
    logic [WD-1:0] cnt;
    logic [WD-1:0] cnt_nxt;
    logic [WD-1:0] active;
    logic [WD-1:0] active_nxt;

    tick_divider #(
        .DW(DW)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .divider(divider),
        .step   (step)
    );

    assign sample_ready = !hold_valid;
    assign accept       = sample_valid && !hold_valid;
    assign boundary     = step && (cnt == LAST);
    assign run          = (mode == RUN);

    // mode follows enable on the edge where it is sampled
    always_comb begin
        mode = IDLE;
        unique case (1'b1)
            enable:  mode = RUN;
            default: mode = IDLE;
        endcase
    end

    // next PWM position and next active duty
    always_comb begin
        cnt_nxt    = cnt;
        active_nxt = active;
        if (!run || boundary) begin
            cnt_nxt = '0;
        end else if (step) begin
            cnt_nxt = cnt + 1'b1;
        end
        if (boundary && hold_valid) begin
            active_nxt = hold;
        end
    end

    // PWM position and duty registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= '0;
        end else begin
            cnt    <= cnt_nxt;
            active <= active_nxt;
        end
    end

    // holding register: fill on accept, drain on boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold       <= sample;
            hold_valid <= 1'b1;
        end else if (boundary) begin
            hold_valid <= 1'b0;
        end
    end

    // outputs use next values so tick lines up with the new duty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            pwm_out     <= run && (active_nxt > cnt_nxt);
            sample_tick <= boundary;
            if (boundary && !hold_valid) begin
                underrun <= 1'b1;
            end else if (underrun_clear) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: period-arithmetic model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pwm_dac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;
    logic [3:0] divider;
    logic       enable;
    logic       underrun_clear;
    logic       pwm_out;
    logic       sample_tick;
    logic       underrun;

    int vec = 0;
    int err = 0;

    pwm_dac dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .divider       (divider),
        .enable        (enable),
        .underrun_clear(underrun_clear),
        .pwm_out       (pwm_out),
        .sample_tick   (sample_tick),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: position = enabled clocks / (divider+1); 255 steps per period
    int         m_k;
    logic       m_full;
    logic [7:0] m_hold;
    logic [7:0] m_active;
    logic       m_pwm;
    logic       m_tick;
    logic       m_und;

    always @(posedge clk or negedge rst_n) begin : mdl
        int k;
        int sn;
        int pos;
        int d;
        bit bnd;
        logic [7:0] act;
        if (!rst_n) begin
            m_k      <= 0;
            m_full   <= 1'b0;
            m_hold   <= 8'h00;
            m_active <= 8'h00;
            m_pwm    <= 1'b0;
            m_tick   <= 1'b0;
            m_und    <= 1'b0;
        end else begin
            d = int'(divider) + 1;
            if (enable) begin
                k   = m_k + 1;
                sn  = k / d;
                pos = sn % 255;
                bnd = ((k % d) == 0) && (pos == 0);
            end else begin
                k   = 0;
                pos = 0;
                bnd = 1'b0;
            end
            act = (bnd && m_full) ? m_hold : m_active;
            m_k      <= k;
            m_active <= act;
            m_pwm    <= enable && (int'(act) > pos);
            m_tick   <= bnd;
            if (sample_valid && !m_full) begin
                m_full <= 1'b1;
                m_hold <= sample;
            end else if (bnd) begin
                m_full <= 1'b0;
            end
            if (bnd && !m_full) m_und <= 1'b1;
            else if (underrun_clear) m_und <= 1'b0;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("pwm_out", int'(pwm_out), int'(m_pwm));
        chk("sample_tick", int'(sample_tick), int'(m_tick));
        chk("underrun", int'(underrun), int'(m_und));
        chk("sample_ready", int'(sample_ready), int'(!m_full));
    end

    task automatic push(input logic [7:0] v);
        sample       = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n, output int h);
        n = 0;
        h = 0;
        do begin
            @(negedge clk);
            n++;
            h += int'(pwm_out);
        end while (!sample_tick && n < 5000);
        if (!sample_tick) chk("tick_timeout", 0, 1);
    endtask

    // from a tick, count clocks and high clocks up to the next tick
    task automatic measure(input bit do_push, input logic [7:0] v,
                           output int gap, output int highs);
        gap          = 1;
        highs        = int'(pwm_out);
        sample       = v;
        sample_valid = do_push;
        @(negedge clk);
        while (!sample_tick && gap < 5000) begin
            if (!sample_ready) sample_valid = 1'b0;
            highs += int'(pwm_out);
            gap++;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        if (!sample_tick) chk("measure_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int h;
        int hi;
        rst_n          = 1'b0;
        sample         = 8'h00;
        sample_valid   = 1'b0;
        divider        = 4'd0;
        enable         = 1'b1;
        underrun_clear = 1'b0;

        // reset state, then starve from the first period
        repeat (2) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_und", int'(underrun), 0);
        chk("rst_ready", int'(sample_ready), 1);
        rst_n = 1'b1;
        wait_tick(n, h);
        chk("first_tick_clocks", n, 255);
        chk("starve_highs", h, 0);
        chk("starve_und", int'(underrun), 1);
        chk("starve_ready", int'(sample_ready), 1);

        // 0x40, then 0x00 and 0xFF back to back
        underrun_clear = 1'b1;
        push(8'h40);
        underrun_clear = 1'b0;
        chk("accept_ready", int'(sample_ready), 0);
        chk("clear_und", int'(underrun), 0);
        wait_tick(n, h);
        chk("load_ready", int'(sample_ready), 1);
        chk("load_und", int'(underrun), 0);
        measure(1'b1, 8'h00, n, h);
        chk("p40_gap", n, 255);
        chk("p40_highs", h, 64);
        chk("p40_und", int'(underrun), 0);
        measure(1'b1, 8'hFF, n, h);
        chk("p00_highs", h, 0);
        measure(1'b0, 8'h00, n, h);
        chk("pff_gap", n, 255);
        chk("pff_highs", h, 255);
        chk("pff_und", int'(underrun), 1);

        // idle: parked output, handshake still fills Hold
        enable         = 1'b0;
        underrun_clear = 1'b1;
        push(8'h80);
        underrun_clear = 1'b0;
        chk("idle_ready", int'(sample_ready), 0);
        chk("idle_und", int'(underrun), 0);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi += int'(pwm_out) + int'(sample_tick);
        end
        chk("idle_quiet", hi, 0);
        chk("idle_hold_full", int'(sample_ready), 0);

        // divider 3: 1020-clock periods
        divider = 4'd3;
        enable  = 1'b1;
        wait_tick(n, h);
        chk("div3_first_tick", n, 1020);
        chk("div3_ff_highs", h, 1020);
        chk("div3_und", int'(underrun), 0);
        measure(1'b0, 8'h00, n, h);
        chk("p80_gap", n, 1020);
        chk("p80_highs", h, 512);
        chk("p80_und", int'(underrun), 1);

        // accept on the boundary edge with Hold empty
        underrun_clear = 1'b1;
        @(negedge clk);
        underrun_clear = 1'b0;
        chk("und_clear1", int'(underrun), 0);
        repeat (1018) @(negedge clk);
        sample       = 8'h30;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("edge_tick", int'(sample_tick), 1);
        chk("edge_und", int'(underrun), 1);
        chk("edge_ready", int'(sample_ready), 0);
        measure(1'b0, 8'h00, n, h);
        chk("retain_gap", n, 1020);
        chk("retain_highs", h, 512);

        // clear and new underrun on the same edge
        underrun_clear = 1'b1;
        @(negedge clk);
        underrun_clear = 1'b0;
        chk("und_clear2", int'(underrun), 0);
        repeat (1018) @(negedge clk);
        underrun_clear = 1'b1;
        @(negedge clk);
        underrun_clear = 1'b0;
        chk("setwin_tick", int'(sample_tick), 1);
        chk("setwin_und", int'(underrun), 1);

        // reset mid-period with Hold full
        push(8'h55);
        chk("pre_rst_ready", int'(sample_ready), 0);
        repeat (100) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_tick", int'(sample_tick), 0);
        chk("mid_rst_und", int'(underrun), 0);
        chk("mid_rst_ready", int'(sample_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n, h);
        chk("post_rst_tick", n, 1020);
        chk("hold_discarded", int'(underrun), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
